// File: rtl/input_port_buffer.sv
// input_port_buffer: first-word-fall-through flit FIFO for one router input
// port, with a registered credit-return pulse and a one-cycle overflow pulse
// whenever an incoming flit is dropped because the FIFO is full.
// Optional macro PORT_STATS_EN adds saturating accept/drop counters.
module input_port_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    data_i,
  input  logic          valid_i,
  input  logic          remove_i,
  input  logic          credit_inc_i,
  output logic [7:0]    data_o,
  output logic          valid_o,
  output logic          full_o,
  output logic [CW-1:0] count_o,
  output logic          credit_o,
  output logic          overflow_o
`ifdef PORT_STATS_EN
  ,
  output logic [15:0]   accept_cnt_o,
  output logic [7:0]    drop_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          credit_q, credit_d;
  logic          pop, push, drop;

`ifdef PORT_STATS_EN
  logic [15:0]   accept_q, accept_d;
  logic [7:0]    drop_q, drop_d;
`endif

  // Push/pop decisions and next-state for pointers, occupancy and pulses
  always_comb begin
    pop        = remove_i && (count_q != '0);
    // A full FIFO still accepts a flit when the head leaves in the same cycle
    push       = valid_i && ((count_q != FULL_CNT) || pop);
    drop       = valid_i && !push;
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    overflow_d = drop;
    credit_d   = credit_inc_i;
  end

`ifdef PORT_STATS_EN
  // Saturating statistics counters
  always_comb begin
    accept_d = accept_q;
    drop_d   = drop_q;
    if (push && (accept_q != '1)) accept_d = accept_q + 16'd1;
    if (drop && (drop_q != '1))   drop_d   = drop_q + 8'd1;
  end
`endif

  // Flit storage; not reset because valid_o gates data_o
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control state with synchronous reset taking priority over all inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      credit_q   <= 1'b0;
`ifdef PORT_STATS_EN
      accept_q   <= '0;
      drop_q     <= '0;
`endif
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      credit_q   <= credit_d;
`ifdef PORT_STATS_EN
      accept_q   <= accept_d;
      drop_q     <= drop_d;
`endif
    end
  end

  assign valid_o    = (count_q != '0);
  assign full_o     = (count_q == FULL_CNT);
  assign count_o    = count_q;
  assign data_o     = valid_o ? mem_q[rd_ptr_q] : '0;
  assign credit_o   = credit_q;
  assign overflow_o = overflow_q;
`ifdef PORT_STATS_EN
  assign accept_cnt_o = accept_q;
  assign drop_cnt_o   = drop_q;
`endif

endmodule

// File: tb/tb_input_port_buffer.sv
// Testbench for input_port_buffer: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the port buffer.
module tb_input_port_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    data_i;
  logic          valid_i;
  logic          remove_i;
  logic          credit_inc_i;
  logic [7:0]    data_o;
  logic          valid_o;
  logic          full_o;
  logic [CW-1:0] count_o;
  logic          credit_o;
  logic          overflow_o;
`ifdef PORT_STATS_EN
  logic [15:0]   accept_cnt_o;
  logic [7:0]    drop_cnt_o;
`endif

  input_port_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .remove_i     (remove_i),
    .credit_inc_i (credit_inc_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .full_o       (full_o),
    .count_o      (count_o),
    .credit_o     (credit_o),
`ifdef PORT_STATS_EN
    .overflow_o   (overflow_o),
    .accept_cnt_o (accept_cnt_o),
    .drop_cnt_o   (drop_cnt_o)
`else
    .overflow_o   (overflow_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] q[$];
  logic       exp_ovf;
  logic       exp_credit;
  int         exp_acc;
  int         exp_drp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic v, input logic [7:0] d, input logic r,
                              input logic c, input logic rs);
    bit popping, pushing;
    if (rs) begin
      q.delete();
      exp_ovf    = 1'b0;
      exp_credit = 1'b0;
      exp_acc    = 0;
      exp_drp    = 0;
    end else begin
      popping = r && (q.size() > 0);
      pushing = v && ((q.size() < DEPTH) || popping);
      if (popping) void'(q.pop_front());
      if (pushing) q.push_back(d);
      exp_ovf    = v && !pushing;
      exp_credit = c;
      if (pushing && exp_acc < 65535) exp_acc++;
      if (exp_ovf && exp_drp < 255)   exp_drp++;
    end
  endtask

  task automatic compare_all();
    check("valid_o", valid_o, q.size() != 0);
    check("full_o", full_o, q.size() == DEPTH);
    check("count_o", count_o, q.size());
    if (q.size() != 0) check("data_o", data_o, q[0]);
    check("credit_o", credit_o, exp_credit);
    check("overflow_o", overflow_o, exp_ovf);
`ifdef PORT_STATS_EN
    check("accept_cnt_o", accept_cnt_o, exp_acc);
    check("drop_cnt_o", drop_cnt_o, exp_drp);
`endif
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge
  task automatic step(input logic v, input logic [7:0] d, input logic r,
                      input logic c, input logic rs);
    valid_i      = v;
    data_i       = d;
    remove_i     = r;
    credit_inc_i = c;
    rst          = rs;
    @(posedge clk);
    #1;
    model_update(v, d, r, c, rs);
    compare_all();
  endtask

  initial begin
    logic [7:0] exp_seq [4];
    int pv;
    exp_seq = '{8'h12, 8'h13, 8'h14, 8'h55};
    q.delete();
    exp_ovf = 1'b0; exp_credit = 1'b0; exp_acc = 0; exp_drp = 0;
    valid_i = 1'b0; data_i = '0; remove_i = 1'b0; credit_inc_i = 1'b0; rst = 1'b1;

    // Reset state
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hAA, 1'b1, 1'b1, 1'b1);
    check("rst_data_o", data_o, 8'h00);
    check("rst_count_o", count_o, 0);
    check("rst_credit_o", credit_o, 0);

    // Single write into empty FIFO appears next cycle
    step(1'b1, 8'h23, 1'b0, 1'b0, 1'b0);
    check("wr23_valid", valid_o, 1);
    check("wr23_data", data_o, 8'h23);
    check("wr23_count", count_o, 1);

    // Simultaneous push and pop on empty FIFO: pop ignored
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h31, 1'b1, 1'b0, 1'b0);
    check("emptyrw_count", count_o, 1);
    check("emptyrw_data", data_o, 8'h31);

    // Fill to DEPTH then overflow
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h15, 1'b0, 1'b0, 1'b0);
    check("ovf_full", full_o, 1);
    check("ovf_pulse", overflow_o, 1);
    check("ovf_head", data_o, 8'h11);
`ifdef PORT_STATS_EN
    check("ovf_drop_cnt", drop_cnt_o, 1);
`endif
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("ovf_pulse_end", overflow_o, 0);

    // Full FIFO with push and pop together
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    check("fullrw_count", count_o, 4);
    check("fullrw_no_ovf", overflow_o, 0);
    for (int i = 0; i < 4; i++) begin
      check("fullrw_drain", data_o, exp_seq[i]);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    check("fullrw_empty", valid_o, 0);

    // Credit pulses: three back-to-back inputs give three back-to-back outputs
    check("cred_idle", credit_o, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("cred_pulse", credit_o, 1);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("cred_end", credit_o, 0);

    // Reset mid-operation with a same-cycle write and credit
    for (int i = 0; i < 3; i++) step(1'b1, 8'h41 + 8'(i), 1'b0, 1'b0, 1'b0);
    check("midrst_pre_count", count_o, 3);
    step(1'b1, 8'h99, 1'b0, 1'b1, 1'b1);
    check("midrst_count", count_o, 0);
    check("midrst_valid", valid_o, 0);
    check("midrst_credit", credit_o, 0);
`ifdef PORT_STATS_EN
    check("midrst_acc", accept_cnt_o, 0);
    check("midrst_drp", drop_cnt_o, 0);
`endif

    // Randomized traffic: push-heavy first half to exercise full/overflow
    for (int i = 0; i < 3000; i++) begin
      pv = (i < 1500) ? 75 : 40;
      step($urandom_range(0, 99) < pv, 8'($urandom), $urandom_range(0, 99) < 45,
           $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
